poci_keys: RTL and testbench

Peripheral-side POCI slave for the push-button keys, sitting directly downstream of the POCI bus decoder in the slave slot selected at `base_keys`. It synchronises and debounces NKEYS asynchronous key pins and latches press events in write-one-to-clear flags. It exposes the debounced state, the flags and an interrupt mask as three word registers, and drives a level interrupt to the core.

---
 rtl/pk_poci.sv | 17 +
 rtl/key_debounce.sv | 66 ++++++
 rtl/poci_keys.sv | 88 ++++++++
 tb/tb_poci_keys.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pk_poci.sv
// Shared POCI slave-map constants: decoder base for the keys slot and its register offsets.
// The key block's debounce option is selected by POCI_KEYS_DEBOUNCE_EN.
package pk_poci;

    localparam logic [31:0] base_keys   = 32'h4000_1000;

    localparam logic [1:0]  KEYS_DATA   = 2'd0;
    localparam logic [1:0]  KEYS_EDGE   = 2'd1;
    localparam logic [1:0]  KEYS_IRQ_EN = 2'd2;
    localparam logic [1:0]  KEYS_RSVD   = 2'd3;

    // Counter must be at least one bit even when a single stable cycle suffices.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: polarity fix, two-flop synchroniser, optional debounce counter (POCI_KEYS_DEBOUNCE_EN)
// and debounced state, with a combinational press pulse aligned to the state's 0->1 edge.
module key_debounce
    import pk_poci::*;
#(
`ifdef POCI_KEYS_DEBOUNCE_EN
    parameter int unsigned DEBOUNCE_CYCLES = 16,
`endif
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic pclk,
    input  logic presetn,
    input  logic key,
    output logic state,
    output logic rise
);

    logic pin;
    logic sync1;
    logic sync2;

    assign pin = key ^ ACTIVE_LOW;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef POCI_KEYS_DEBOUNCE_EN
    localparam int unsigned   CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync2 != state) && (cnt == CMAX);
    assign rise = flip & ~state;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (sync2 == state) begin
            cnt <= '0;
        end else if (flip) begin
            cnt   <= '0;
            state <= ~state;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    assign rise = sync2 & ~state;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= 1'b0;
        else          state <= sync2;
    end
`endif

endmodule

// File: rtl/poci_keys.sv
// POCI slave for NKEYS push-buttons: DATA/EDGE(W1C)/IRQ_EN registers and a registered level irq.
// Debounce counters are built only when POCI_KEYS_DEBOUNCE_EN is defined.
module poci_keys
    import pk_poci::*;
#(
    parameter int unsigned NKEYS           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic [31:0]       paddr,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [NKEYS-1:0]  keys,
    output logic              irq
);

    logic [NKEYS-1:0] state;
    logic [NKEYS-1:0] rise;
    logic [NKEYS-1:0] edges;
    logic [NKEYS-1:0] irq_en;
    logic [NKEYS-1:0] clr;
    logic [1:0]       off;
    logic             wr;
    logic             unused_bits;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce #(
            .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef POCI_KEYS_DEBOUNCE_EN
            ,.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_key (
            .pclk    (pclk),
            .presetn (presetn),
            .key     (keys[i]),
            .state   (state[i]),
            .rise    (rise[i])
        );
    end

`ifndef POCI_KEYS_DEBOUNCE_EN
    localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;
`endif

    assign off         = paddr[3:2];
    assign wr          = psel & penable & pwrite;
    assign pready      = 1'b1;
    assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata};

    assign pslverr = psel & penable &
                     ((pwrite & ((off == KEYS_DATA) | (off == KEYS_RSVD))) |
                      (~pwrite & (off == KEYS_RSVD)));

    always_comb begin
        prdata = '0;
        if (psel & ~pwrite) begin
            case (off)
                KEYS_DATA:   prdata[NKEYS-1:0] = state;
                KEYS_EDGE:   prdata[NKEYS-1:0] = edges;
                KEYS_IRQ_EN: prdata[NKEYS-1:0] = irq_en;
                default:     prdata = '0;
            endcase
        end
    end

    assign clr = (wr && off == KEYS_EDGE) ? pwdata[NKEYS-1:0] : '0;

    // A press landing on the same edge as its W1C clear keeps the flag set.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            edges  <= '0;
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            edges <= (edges & ~clr) | rise;
            if (wr && off == KEYS_IRQ_EN) irq_en <= pwdata[NKEYS-1:0];
            irq <= |(edges & irq_en);
        end
    end

endmodule

// File: tb/tb_poci_keys.sv
// Directed bench for poci_keys; expected latencies follow POCI_KEYS_DEBOUNCE_EN when defined.
module tb_poci_keys;
    import pk_poci::*;

    localparam int unsigned NK  = 4;
    localparam int unsigned DEB = 16;
`ifdef POCI_KEYS_DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 3;
`endif

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr, irq;
    logic [NK-1:0] keys;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd;
    logic        err;

    poci_keys #(
        .NKEYS           (NK),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .paddr   (paddr),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .keys    (keys),
        .irq     (irq)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] o, output logic [31:0] d, output logic e);
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = base_keys | {28'h0, o, 2'b00};
        #1;
        d = prdata;
        e = pslverr;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] o, input logic [31:0] d,
                             output logic e, output logic [31:0] rdw);
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = base_keys | {28'h0, o, 2'b00};
        pwdata  = d;
        #1;
        e   = pslverr;
        rdw = prdata;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    initial begin
        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        keys = 4'hF;
        step(3);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
        chk("rst_pready", {31'h0, pready}, 32'h1);
        chk("rst_prdata_idle", prdata, 32'h0);
        presetn = 1'b1;
        bus_read(KEYS_DATA, rd, err);   chk("rst_data", rd, 32'h0);
        bus_read(KEYS_EDGE, rd, err);   chk("rst_edge", rd, 32'h0);
        bus_read(KEYS_IRQ_EN, rd, err); chk("rst_irqen", rd, 32'h0);

        // press key 0 with irq enabled
        bus_write(KEYS_IRQ_EN, 32'h1, err, rd);
        keys[0] = 1'b0;
        step(LAT - 1);
        bus_read(KEYS_DATA, rd, err); chk("k0_data_early", rd, 32'h0);
        bus_read(KEYS_EDGE, rd, err); chk("k0_edge_early", rd, 32'h0);
        step(1);
        bus_read(KEYS_DATA, rd, err); chk("k0_data", rd, 32'h1);
        bus_read(KEYS_EDGE, rd, err); chk("k0_edge", rd, 32'h1);
        chk("k0_irq_early", {31'h0, irq}, 32'h0);
        step(1);
        chk("k0_irq", {31'h0, irq}, 32'h1);

        bus_write(KEYS_EDGE, 32'h1, err, rd);
        bus_read(KEYS_EDGE, rd, err); chk("w1c_edge", rd, 32'h0);
        chk("w1c_irq_hold", {31'h0, irq}, 32'h1);
        step(1);
        chk("w1c_irq_drop", {31'h0, irq}, 32'h0);

        keys[0] = 1'b1;
        step(LAT + 1);
        bus_read(KEYS_DATA, rd, err); chk("rel_data", rd, 32'h0);
        bus_read(KEYS_EDGE, rd, err); chk("rel_edge", rd, 32'h0);

        // 10-cycle pulse on key 1
        keys[1] = 1'b0;
        step(10);
        keys[1] = 1'b1;
`ifdef POCI_KEYS_DEBOUNCE_EN
        bus_read(KEYS_DATA, rd, err); chk("glitch_data_mid", rd, 32'h0);
        step(LAT + 2);
        bus_read(KEYS_DATA, rd, err); chk("glitch_data", rd, 32'h0);
        bus_read(KEYS_EDGE, rd, err); chk("glitch_edge", rd, 32'h0);
`else
        bus_read(KEYS_DATA, rd, err); chk("pulse_data_mid", rd, 32'h2);
        step(LAT + 2);
        bus_read(KEYS_DATA, rd, err); chk("pulse_data", rd, 32'h0);
        bus_read(KEYS_EDGE, rd, err); chk("pulse_edge", rd, 32'h2);
        bus_write(KEYS_EDGE, 32'h2, err, rd);
`endif

        // build EDGE = 3, partial clear, then set-wins collision on bit 1
        keys = 4'b1100;
        step(LAT);
        bus_read(KEYS_DATA, rd, err); chk("two_data", rd, 32'h3);
        bus_read(KEYS_EDGE, rd, err); chk("two_edge", rd, 32'h3);
        keys = 4'hF;
        step(LAT + 1);
        bus_read(KEYS_DATA, rd, err); chk("two_rel_data", rd, 32'h0);
        bus_read(KEYS_EDGE, rd, err); chk("two_rel_edge", rd, 32'h3);
        bus_write(KEYS_EDGE, 32'h1, err, rd);
        bus_read(KEYS_EDGE, rd, err); chk("w1c_bit0", rd, 32'h2);
        keys[1] = 1'b0;
        step(LAT - 1);
        bus_write(KEYS_EDGE, 32'h2, err, rd);
        bus_read(KEYS_EDGE, rd, err); chk("set_wins", rd, 32'h2);
        bus_read(KEYS_DATA, rd, err); chk("set_wins_data", rd, 32'h2);
        bus_write(KEYS_IRQ_EN, 32'h2, err, rd);
        chk("en2_irq_early", {31'h0, irq}, 32'h0);
        step(1);
        chk("en2_irq", {31'h0, irq}, 32'h1);

        // error accesses
        bus_write(KEYS_DATA, 32'hF, err, rd);
        chk("wr_data_err", {31'h0, err}, 32'h1);
        chk("wr_prdata_zero", rd, 32'h0);
        bus_write(KEYS_RSVD, 32'hF, err, rd);
        chk("wr_rsvd_err", {31'h0, err}, 32'h1);
        bus_read(KEYS_RSVD, rd, err);
        chk("rd_rsvd_err", {31'h0, err}, 32'h1);
        chk("rd_rsvd_data", rd, 32'h0);
        bus_read(KEYS_DATA, rd, err);
        chk("data_unchanged", rd, 32'h2);
        chk("rd_data_noerr", {31'h0, err}, 32'h0);

        // reset mid-debounce with keys 0 and 1 held
        keys[0] = 1'b0;
        step(11);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        presetn = 1'b0;
        #1;
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        bus_read(KEYS_DATA, rd, err);   chk("mid_rst_data", rd, 32'h0);
        bus_read(KEYS_EDGE, rd, err);   chk("mid_rst_edge", rd, 32'h0);
        bus_read(KEYS_IRQ_EN, rd, err); chk("mid_rst_irqen", rd, 32'h0);
        chk("mid_rst_pslverr", {31'h0, pslverr}, 32'h0);
        step(2);
        presetn = 1'b1;
        step(LAT - 1);
        bus_read(KEYS_DATA, rd, err); chk("post_rst_early", rd, 32'h0);
        step(1);
        bus_read(KEYS_DATA, rd, err); chk("post_rst_data", rd, 32'h3);
        bus_read(KEYS_EDGE, rd, err); chk("post_rst_edge", rd, 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
